traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Safety monitor on the receiving end of the four light buses (light_M1, light_S, light_M2, light_MT) driven by the intersection controller.
- Samples all four lanes every clk and checks lamp encoding, conflicting right-of-way, the G->Y->R->G sequence and the minimum amber time.
- On the first violation it latches a fault record and drives a flash-mode request to the cabinet.
- Runs on the controller's 1 Hz clk (one cycle = 1 s).

Parameters:
- MIN_YELLOW, 3, minimum consecutive yellow cycles before red is allowed (>=1).
- FLASH_DIV, 1, cycles per half-period of flash_o while faulted (>=1).
- MAX_HOLD, 60, watchdog limit in cycles with no lane change (used only with WATCHDOG_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- light_M1  input  3  main road dir 1 lamp; {R,Y,G} one-hot, bit2=red, bit1=yellow, bit0=green.
- light_S  input  3  side road lamp, same encoding.
- light_M2  input  3  main road dir 2 lamp, same encoding.
- light_MT  input  3  main turn lamp, same encoding.
- clear_fault  input  1  synchronous single-cycle pulse; clears the latched fault and re-arms.
- fault_o  output  1  sticky fault flag.
- fault_code  output  3  0 none, 1 ENCODING, 2 CONFLICT, 3 SEQUENCE, 4 SHORT_YELLOW, 5 STUCK.
- fault_lane  output  2  0 M1, 1 S, 2 M2, 3 MT; lane of the first violation.
- flash_o  output  1  flash-mode request; toggles while faulted.

Behaviour:
- Reset (async, rst=1): fault_o=0, fault_code=0, fault_lane=0, flash_o=0, armed=0, yellow counters=0, previous-lamp registers=3'b100.
- Arming: the first clk after reset release, or after clear_fault, captures the current lamps into the previous-lamp registers and sets armed=1.
  - No sequence or short-yellow check is made on that cycle.
  - Encoding and conflict checks are always active.
- ENCODING: a lane value that is not exactly one-hot (000, 011, 111, ...) is a fault.
- CONFLICT: any non-red (G or Y) on both lanes of a conflicting pair: S–M1, S–M2, S–MT, M2–MT. M1–M2 and M1–MT are compatible. Reported lane = lower index of the pair.
- SEQUENCE (armed only): legal per-lane transitions are hold, G->Y, Y->R, R->G. Any other transition (G->R, R->Y, Y->G) is a fault.
- SHORT_YELLOW: a per-lane counter increments while yellow and saturates at MIN_YELLOW; it loads 1 on entering yellow and 0 when not yellow. A Y->R transition with counter < MIN_YELLOW is a fault.
  - Example: MIN_YELLOW=3 and yellow held 2 cycles -> fault on the red cycle.
- Detection is combinational on the sampled inputs; the fault registers update on the same clk edge. Latency = 1 cycle from the offending input to fault_o=1.
- Simultaneous violations: code priority ENCODING > CONFLICT > SEQUENCE > SHORT_YELLOW > STUCK. Within a code, lane priority M1 > S > M2 > MT.
- Latching:
  - Only the first fault is recorded; later violations do not change code or lane.
  - While faulted, the sequence checks are suspended. The previous-lamp registers keep tracking the inputs.
- flash_o: 0 when not faulted. After fault_o rises, flash_o goes to 1 on the next edge, then toggles every FLASH_DIV cycles. The divider counter resets on fault entry.
- clear_fault:
  - When fault_o=1, it clears fault_o, code, lane, flash_o and the divider and sets armed=0, so the monitor re-arms on the next cycle.
  - If a violation is present in the same cycle as clear_fault, clear wins; the violation is re-detected on later cycles if it persists.
  - When fault_o=0, clear_fault has no effect.
- rst asserted mid-operation returns everything to the reset values immediately (asynchronous).

Optional Feature:
- Macro: TLM_WATCHDOG_EN.
- Defined: a hold counter resets on any change of any lane or on re-arm, and counts otherwise. Reaching MAX_HOLD consecutive unchanged cycles raises STUCK with fault_lane=0. The counter saturates and does not run while faulted.
- Undefined: no hold counter is instantiated, code 5 is never produced and MAX_HOLD is ignored.

Test Plan:
- Reset then legal cycle, lamps updated once per cycle: M1,M2=G, S,MT=R for 10 cycles; M1,M2=Y for 3; M1,M2=R and S=G for 10; S=Y for 3; S=R and MT=G for 5 -> fault_o stays 0 and flash_o stays 0 throughout.
- From an armed legal state, set S=G while M1=G -> next edge fault_o=1, fault_code=2, fault_lane=0; flash_o=1 on the following edge and toggles every cycle after that.
- With the monitor armed, M2 goes G->R directly -> fault_code=3, fault_lane=2. A subsequent conflict does not change code or lane.
- M1 holds Y for 2 cycles, then R -> fault_code=4, fault_lane=0. Pulse clear_fault -> fault_o=0, flash_o=0; the next legal sequence raises no fault.
- Drive light_MT=3'b011 -> fault_code=1, fault_lane=3. Assert rst mid-fault -> all outputs return to 0 asynchronously, before the next clk edge.
- With TLM_WATCHDOG_EN defined and MAX_HOLD=5, hold all lamps constant -> fault_code=5 after 5 cycles. With the macro undefined, no fault ever occurs.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - safety monitor for four intersection lamp buses; latches first fault, requests flash.
// Optional lamp-hold watchdog (STUCK, code 5) enabled by defining TLM_WATCHDOG_EN.
module traffic_light_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_DIV  = 1,
  parameter int MAX_HOLD   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_S,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic       clear_fault,
  output logic       fault_o,
  output logic [2:0] fault_code,
  output logic [1:0] fault_lane,
  output logic       flash_o
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int DW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);
  localparam logic [DW-1:0] DMAX = DW'(FLASH_DIV - 1);

  logic [3:0][2:0]    lamp;
  logic [3:0][2:0]    prev_q, prev_d;
  logic [3:0][YW-1:0] ycnt_q, ycnt_d;
  logic               armed_q, armed_d;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;
  logic [1:0]         lane_q, lane_d;
  logic               flash_q, flash_d;
  logic [DW-1:0]      div_q, div_d;
  logic [4:1][3:0]    bad;
  logic [3:0]         go;
  logic               chk, found, stuck;
  logic [2:0]         vcode;
  logic [1:0]         vlane;

  // Lane index order doubles as the lane priority: 0=M1, 1=S, 2=M2, 3=MT.
  assign lamp = {light_MT, light_M2, light_S, light_M1};

`ifdef TLM_WATCHDOG_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;
  logic          changed;

  always_comb begin
    changed = (lamp != prev_q);
    hold_d  = hold_q;
    if (!armed_q || changed) hold_d = '0;
    else if (!fault_q && hold_q != HMAX) hold_d = hold_q + HW'(1);
  end

  assign stuck = armed_q && !fault_q && !changed && (hold_q >= HMAX - HW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  logic unused_max_hold;
  assign stuck           = 1'b0;
  assign unused_max_hold = (MAX_HOLD != 0);
`endif

  always_comb begin
    chk   = armed_q && !fault_q;
    go    = '0;
    bad   = '0;
    found = 1'b0;
    vcode = 3'd0;
    vlane = 2'd0;
    for (int i = 0; i < 4; i++) begin
      go[i]     = |lamp[i][1:0];
      bad[1][i] = !$onehot(lamp[i]);
      bad[3][i] = chk && ((prev_q[i] == GRN && lamp[i] == RED) ||
                          (prev_q[i] == RED && lamp[i] == YEL) ||
                          (prev_q[i] == YEL && lamp[i] == GRN));
      bad[4][i] = chk && prev_q[i] == YEL && lamp[i] == RED && ycnt_q[i] < YMAX;
      ycnt_d[i] = (lamp[i] != YEL) ? '0 :
                  (ycnt_q[i] == YMAX) ? YMAX : ycnt_q[i] + YW'(1);
    end
    // Conflicting pairs reported at their lower lane index.
    bad[2][0] = go[1] && go[0];
    bad[2][1] = go[1] && (go[2] || go[3]);
    bad[2][2] = go[2] && go[3];
    for (int c = 1; c <= 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!found && bad[c][i]) begin
          found = 1'b1;
          vcode = 3'(c);
          vlane = 2'(i);
        end
      end
    end
    if (!found && stuck) begin
      found = 1'b1;
      vcode = 3'd5;
      vlane = 2'd0;
    end

    prev_d  = lamp;
    armed_d = 1'b1;
    fault_d = fault_q;
    code_d  = code_q;
    lane_d  = lane_q;
    flash_d = flash_q;
    div_d   = div_q;
    if (fault_q) begin
      if (clear_fault) begin
        armed_d = 1'b0;
        fault_d = 1'b0;
        code_d  = 3'd0;
        lane_d  = 2'd0;
        flash_d = 1'b0;
        div_d   = '0;
      end else if (div_q == '0) begin
        flash_d = !flash_q;
        div_d   = DMAX;
      end else begin
        div_d = div_q - DW'(1);
      end
    end else if (found) begin
      fault_d = 1'b1;
      code_d  = vcode;
      lane_d  = vlane;
      flash_d = 1'b0;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= {4{RED}};
      ycnt_q  <= '0;
      armed_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      lane_q  <= 2'd0;
      flash_q <= 1'b0;
      div_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      ycnt_q  <= ycnt_d;
      armed_q <= armed_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      lane_q  <= lane_d;
      flash_q <= flash_d;
      div_q   <= div_d;
    end
  end

  assign fault_o    = fault_q;
  assign fault_code = code_q;
  assign fault_lane = lane_q;
  assign flash_o    = flash_q;

endmodule
